// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: deserialises MOSI bytes into a bank at a self-incrementing address and
// serialises tx_data from the same address onto MISO. Optional frame_err under SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk_i,
    input  logic         cs_n_i,
    input  logic         mosi_i,
    output logic         miso_o,
    input  logic [7:0]   tx_data,
    output logic [N:0]   addr1,
    output logic [7:0]   rx_data,
    output logic         wr_en,
    output logic [N+1:0] n_rx_end,
    output logic         rx_ready,
    output logic         busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic         frame_err
`endif
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StShift = 3'd1;
    localparam logic [2:0] StStore = 3'd2;
    localparam logic [2:0] StLoad  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [2:0]   sclk_q, cs_q;
    logic [1:0]   mosi_q;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic [7:0]   tx_shift_q, tx_shift_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic [N:0]   addr_q, addr_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         wr_en_q, wr_en_d;
    logic [N+1:0] n_rx_q, n_rx_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic         frame_err_q, frame_err_d;
    logic         partial_q, partial_d;
`endif

    logic sclk_rise, sclk_fall, cs_fall, cs_hi;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_hi     = cs_q[1];

    // Sync chains reset low so a cs_n_i held low through reset release is not seen as a fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q     <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            state_q    <= StIdle;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            rx_data_q  <= '0;
            wr_en_q    <= 1'b0;
            n_rx_q     <= '0;
        end else begin
            sclk_q     <= {sclk_q[1:0], sclk_i};
            cs_q       <= {cs_q[1:0], cs_n_i};
            mosi_q     <= {mosi_q[0], mosi_i};
            state_q    <= state_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            rx_data_q  <= rx_data_d;
            wr_en_q    <= wr_en_d;
            n_rx_q     <= n_rx_d;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
            partial_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            partial_q   <= partial_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        rx_data_d  = rx_data_q;
        wr_en_d    = 1'b0;
        n_rx_d     = n_rx_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = frame_err_q;
        partial_d   = partial_q;
`endif
        case (state_q)
            StIdle: begin
                // Route through LOAD so the first tx byte is read at the cleared address.
                if (cs_fall) begin
                    addr_d    = '0;
                    n_rx_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = StLoad;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = 1'b0;
                    partial_d   = 1'b0;
`endif
                end
            end
            StShift: begin
                if (sclk_rise && bit_cnt_q == 4'd7) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
                    rx_data_d  = {rx_shift_q[6:0], mosi_q[1]};
                    wr_en_d    = 1'b1;
                    bit_cnt_d  = 4'd8;
                    state_d    = StStore;
                end else if (cs_hi) begin
                    state_d = StDone;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    partial_d = (bit_cnt_q != 4'd0);
`endif
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end else if (sclk_fall && bit_cnt_q != 4'd0) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            StStore: begin
                if (n_rx_q != '1) begin
                    n_rx_d = n_rx_q + 1'b1;
                end
                addr_d  = addr_q + 1'b1;
                state_d = cs_hi ? StDone : StLoad;
            end
            StLoad: begin
                tx_shift_d = tx_data;
                bit_cnt_d  = '0;
                state_d    = cs_hi ? StDone : StShift;
            end
            StDone: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
                frame_err_d = partial_q;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign miso_o   = (state_q == StShift) ? tx_shift_q[7] : 1'b0;
    assign addr1    = addr_q;
    assign rx_data  = rx_data_q;
    assign wr_en    = wr_en_q;
    assign n_rx_end = n_rx_q;
    assign rx_ready = (state_q == StDone) && (n_rx_q != '0);
    assign busy     = (state_q != StIdle);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule
